regfile_param: RTL and testbench

- Parametrised successor to the lab-1 ARM64 register file: configurable data width, register count and number of read ports.
- Two write ports with defined collision priority.
- Optional hardwired-zero register (XZR) and optional write-to-read bypass.
- Sits in the datapath between the decode stage (register addresses) and the execute stage (operands). The writeback stage drives the write ports.

---
 rtl/regfile_param.sv | 124 ++++++++++++
 tb/tb_regfile_param.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param
// Parametrised multi-port register file for the ARM64-style datapath. Decode
// supplies the read addresses, execute consumes the operands, and writeback
// drives the two write ports.
//
// Parameters:
//   WIDTH      data width in bits
//   ADDR_BITS  address width; DEPTH = 2**ADDR_BITS registers
//   NUM_READ   number of combinational read ports (1..8)
//   ZERO_EN    1 = register ZERO_IDX is hardwired to zero
//   ZERO_IDX   index of the hardwired-zero register
//   BYPASS_EN  1 = same-cycle write data is forwarded to matching reads
//
// Ports:
//   clk             rising-edge clock
//   reset_n         asynchronous active-low reset
//   WriteEnable0/1  write port enables
//   WriteRegister0/1 write port addresses
//   WriteData0/1    write port data
//   ReadRegister    packed read addresses, port k at [k*ADDR_BITS +: ADDR_BITS]
//   ReadData        packed read data, port k at [k*WIDTH +: WIDTH]
//   WriteConflict   one-cycle flag after both ports wrote the same register
// -----------------------------------------------------------------------------
module regfile_param #(
   parameter int WIDTH     = 64,
   parameter int ADDR_BITS = 5,
   parameter int NUM_READ  = 2,
   parameter int ZERO_EN   = 1,
   parameter int ZERO_IDX  = 31,
   parameter int BYPASS_EN = 1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          WriteEnable0,
   input  logic [ADDR_BITS-1:0]          WriteRegister0,
   input  logic [WIDTH-1:0]              WriteData0,
   input  logic                          WriteEnable1,
   input  logic [ADDR_BITS-1:0]          WriteRegister1,
   input  logic [WIDTH-1:0]              WriteData1,
   input  logic [NUM_READ*ADDR_BITS-1:0] ReadRegister,
   output logic [NUM_READ*WIDTH-1:0]     ReadData,
   output logic                          WriteConflict
);

   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] ZERO_ADDR = ADDR_BITS'(ZERO_IDX);

   logic [WIDTH-1:0] r_regs [DEPTH];
   logic             r_writeConflict;

   logic w_zeroHit0;
   logic w_zeroHit1;
   logic w_we0;
   logic w_we1;
   logic w_collide;

   // Writes aimed at the zero register are dropped before they reach the
   // array, so the zero slot keeps its reset value and never needs a read-side
   // special case for storage. Collisions are judged on the effective enables,
   // which is why two writes to the zero register do not raise WriteConflict.
   assign w_zeroHit0 = (ZERO_EN != 0) && (WriteRegister0 == ZERO_ADDR);
   assign w_zeroHit1 = (ZERO_EN != 0) && (WriteRegister1 == ZERO_ADDR);
   assign w_we0      = WriteEnable0 && !w_zeroHit0;
   assign w_we1      = WriteEnable1 && !w_zeroHit1;
   assign w_collide  = w_we0 && w_we1 && (WriteRegister0 == WriteRegister1);

   // Register array. Port 1 is written after port 0 in the same block, so on an
   // address collision the later non-blocking assignment (port 1) takes effect.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         if (w_we0) begin
            r_regs[WriteRegister0] <= WriteData0;
         end
         if (w_we1) begin
            r_regs[WriteRegister1] <= WriteData1;
         end
      end
   end

   // Collision flag: a single-cycle pulse following the colliding edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_writeConflict <= 1'b0;
      end else begin
         r_writeConflict <= w_collide;
      end
   end

   assign WriteConflict = r_writeConflict;

   // One independent combinational read path per port. Bypass is gated by
   // reset_n so every port reads zero while reset is held, and port 1 is
   // checked last so it wins when both writes match. The zero-register rule is
   // applied last so it overrides any forwarded value.
   for (genvar k = 0; k < NUM_READ; k++) begin : g_read
      logic [ADDR_BITS-1:0] w_rdAddr;
      logic [WIDTH-1:0]     w_rdData;

      assign w_rdAddr = ReadRegister[k*ADDR_BITS +: ADDR_BITS];

      always_comb begin
         w_rdData = r_regs[w_rdAddr];
         if ((BYPASS_EN != 0) && reset_n) begin
            if (w_we0 && (w_rdAddr == WriteRegister0)) begin
               w_rdData = WriteData0;
            end
            if (w_we1 && (w_rdAddr == WriteRegister1)) begin
               w_rdData = WriteData1;
            end
         end
         if ((ZERO_EN != 0) && (w_rdAddr == ZERO_ADDR)) begin
            w_rdData = '0;
         end
      end

      assign ReadData[k*WIDTH +: WIDTH] = w_rdData;
   end

endmodule

// File: tb/tb_regfile_param.sv
// -----------------------------------------------------------------------------
// tb_regfile_param
// Directed testbench for regfile_param. Three instances share one clock and
// reset: dutA uses default parameters, dutB disables bypass, dutC is the
// reduced 32-bit / 16-entry / 3-read-port configuration without a zero
// register. A table of hand-computed vectors drives dutA/dutB; reset, bypass
// and the reduced configuration are exercised by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_regfile_param;

   typedef struct {
      logic        we0;
      logic [4:0]  wa0;
      logic [63:0] wd0;
      logic        we1;
      logic [4:0]  wa1;
      logic [63:0] wd1;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [63:0] expA0;
      logic [63:0] expA1;
      logic [63:0] expB0;
      logic        expConf;
   } vec_t;

   logic        clk;
   logic        reset_n;

   logic        we0;
   logic [4:0]  wa0;
   logic [63:0] wd0;
   logic        we1;
   logic [4:0]  wa1;
   logic [63:0] wd1;
   logic [9:0]  ra;
   logic [127:0] rdA;
   logic [127:0] rdB;
   logic        confA;
   logic        confB;

   logic        cWe0;
   logic [3:0]  cWa0;
   logic [31:0] cWd0;
   logic        cWe1;
   logic [3:0]  cWa1;
   logic [31:0] cWd1;
   logic [11:0] cRa;
   logic [95:0] cRd;
   logic        cConf;

   int nCompared;
   int nMismatched;

   vec_t vecs [12];

   regfile_param dutA (
      .clk(clk), .reset_n(reset_n),
      .WriteEnable0(we0), .WriteRegister0(wa0), .WriteData0(wd0),
      .WriteEnable1(we1), .WriteRegister1(wa1), .WriteData1(wd1),
      .ReadRegister(ra), .ReadData(rdA), .WriteConflict(confA)
   );

   regfile_param #(.BYPASS_EN(0)) dutB (
      .clk(clk), .reset_n(reset_n),
      .WriteEnable0(we0), .WriteRegister0(wa0), .WriteData0(wd0),
      .WriteEnable1(we1), .WriteRegister1(wa1), .WriteData1(wd1),
      .ReadRegister(ra), .ReadData(rdB), .WriteConflict(confB)
   );

   regfile_param #(
      .WIDTH(32), .ADDR_BITS(4), .NUM_READ(3), .ZERO_EN(0), .ZERO_IDX(0)
   ) dutC (
      .clk(clk), .reset_n(reset_n),
      .WriteEnable0(cWe0), .WriteRegister0(cWa0), .WriteData0(cWd0),
      .WriteEnable1(cWe1), .WriteRegister1(cWa1), .WriteData1(cWd1),
      .ReadRegister(cRa), .ReadData(cRd), .WriteConflict(cConf)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      we0 = v.we0;
      wa0 = v.wa0;
      wd0 = v.wd0;
      we1 = v.we1;
      wa1 = v.wa1;
      wd1 = v.wd1;
      ra  = {v.ra1, v.ra0};
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;

      //                we0  wa0    wd0                  we1  wa1    wd1       ra0    ra1    expA0     expA1     expB0     conf
      vecs[0]  = '{1'b1, 5'd5,  64'h1111,           1'b1, 5'd6,  64'h2222, 5'd5,  5'd6,  64'h1111, 64'h2222, 64'h0,    1'b0};
      vecs[1]  = '{1'b0, 5'd0,  64'h0,              1'b0, 5'd0,  64'h0,    5'd5,  5'd6,  64'h1111, 64'h2222, 64'h1111, 1'b0};
      vecs[2]  = '{1'b1, 5'd7,  64'hAAAA,           1'b1, 5'd7,  64'hBBBB, 5'd7,  5'd7,  64'hBBBB, 64'hBBBB, 64'h0,    1'b1};
      vecs[3]  = '{1'b0, 5'd0,  64'h0,              1'b0, 5'd0,  64'h0,    5'd7,  5'd5,  64'hBBBB, 64'h1111, 64'hBBBB, 1'b0};
      vecs[4]  = '{1'b1, 5'd31, 64'hFFFFFFFFFFFFFFFF, 1'b0, 5'd0,  64'h0,  5'd31, 5'd31, 64'h0,    64'h0,    64'h0,    1'b0};
      vecs[5]  = '{1'b1, 5'd31, 64'h1,              1'b1, 5'd31, 64'h2,    5'd31, 5'd7,  64'h0,    64'hBBBB, 64'h0,    1'b0};
      vecs[6]  = '{1'b0, 5'd0,  64'h0,              1'b0, 5'd0,  64'h0,    5'd31, 5'd31, 64'h0,    64'h0,    64'h0,    1'b0};
      vecs[7]  = '{1'b1, 5'd9,  64'h10,             1'b0, 5'd0,  64'h0,    5'd9,  5'd0,  64'h10,   64'h0,    64'h0,    1'b0};
      vecs[8]  = '{1'b0, 5'd0,  64'h0,              1'b1, 5'd9,  64'h20,   5'd9,  5'd9,  64'h20,   64'h20,   64'h10,   1'b0};
      vecs[9]  = '{1'b0, 5'd0,  64'h0,              1'b0, 5'd0,  64'h0,    5'd9,  5'd3,  64'h20,   64'h0,    64'h20,   1'b0};
      vecs[10] = '{1'b1, 5'd0,  64'h5,              1'b1, 5'd1,  64'h6,    5'd1,  5'd0,  64'h6,    64'h5,    64'h0,    1'b0};
      vecs[11] = '{1'b0, 5'd0,  64'h0,              1'b0, 5'd0,  64'h0,    5'd0,  5'd1,  64'h5,    64'h6,    64'h5,    1'b0};

      // Reset held from time zero with a write pending: reads stay zero.
      reset_n = 1'b0;
      we0 = 1'b1; wa0 = 5'd3; wd0 = 64'hDEADBEEF_00000001;
      we1 = 1'b0; wa1 = 5'd0; wd1 = 64'h0;
      ra  = {5'd3, 5'd3};
      cWe0 = 1'b0; cWa0 = 4'd0; cWd0 = 32'h0;
      cWe1 = 1'b0; cWa1 = 4'd0; cWd1 = 32'h0;
      cRa  = 12'h0;
      #3;
      checkOutput("reset_bypass_suppressed_p0", rdA[63:0], 64'h0);
      checkOutput("reset_bypass_suppressed_p1", rdA[127:64], 64'h0);
      checkOutput("reset_nobypass_p0", rdB[63:0], 64'h0);
      checkOutput("reset_conflict", {63'h0, confA}, 64'h0);

      // Release, let X3 be written, then pull reset mid-cycle.
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("x3_written_p0", rdA[63:0], 64'hDEADBEEF_00000001);
      checkOutput("x3_written_nobypass", rdB[63:0], 64'hDEADBEEF_00000001);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async_reset_p0", rdA[63:0], 64'h0);
      checkOutput("async_reset_p1", rdA[127:64], 64'h0);
      checkOutput("async_reset_nobypass", rdB[63:0], 64'h0);
      checkOutput("async_reset_conflict", {63'h0, confA}, 64'h0);
      @(negedge clk);
      reset_n = 1'b1;
      we0 = 1'b0;
      #2;
      checkOutput("write_lost_under_reset", rdA[63:0], 64'h0);

      // Table-driven vectors: same-cycle reads before the edge, flag after it.
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i]);
         #2;
         checkOutput($sformatf("vec%0d_rdA0", i), rdA[63:0], vecs[i].expA0);
         checkOutput($sformatf("vec%0d_rdA1", i), rdA[127:64], vecs[i].expA1);
         checkOutput($sformatf("vec%0d_rdB0", i), rdB[63:0], vecs[i].expB0);
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d_conf", i), {63'h0, confA}, {63'h0, vecs[i].expConf});
      end

      // Bypass versus no bypass on X9 with a known prior value.
      @(negedge clk);
      we0 = 1'b1; wa0 = 5'd9; wd0 = 64'h10;
      we1 = 1'b0;
      ra  = {5'd0, 5'd9};
      @(negedge clk);
      wd0 = 64'h20;
      #2;
      checkOutput("bypass_new_value", rdA[63:0], 64'h20);
      checkOutput("nobypass_old_value", rdB[63:0], 64'h10);
      @(negedge clk);
      we0 = 1'b0;
      #2;
      checkOutput("nobypass_next_cycle", rdB[63:0], 64'h20);
      checkOutput("bypass_next_cycle", rdA[63:0], 64'h20);

      // Reduced configuration: reg0 is ordinary, read on all three ports.
      @(negedge clk);
      cWe0 = 1'b1; cWa0 = 4'd0; cWd0 = 32'h5A5A5A5A;
      @(negedge clk);
      cWe0 = 1'b0;
      cRa  = {4'd0, 4'd0, 4'd0};
      #2;
      checkOutput("c_reg0_p0", {32'h0, cRd[31:0]}, 64'h5A5A5A5A);
      checkOutput("c_reg0_p1", {32'h0, cRd[63:32]}, 64'h5A5A5A5A);
      checkOutput("c_reg0_p2", {32'h0, cRd[95:64]}, 64'h5A5A5A5A);

      // Collision on reg0 counts when there is no zero register.
      @(negedge clk);
      cWe0 = 1'b1; cWa0 = 4'd0; cWd0 = 32'h1234;
      cWe1 = 1'b1; cWa1 = 4'd0; cWd1 = 32'h5678;
      @(posedge clk);
      #1;
      checkOutput("c_conflict_reg0", {63'h0, cConf}, 64'h1);
      @(negedge clk);
      cWe0 = 1'b0;
      cWe1 = 1'b0;
      #2;
      checkOutput("c_reg0_port1_wins", {32'h0, cRd[31:0]}, 64'h5678);
      @(posedge clk);
      #1;
      checkOutput("c_conflict_cleared", {63'h0, cConf}, 64'h0);

      // Walking ones across all 16 registers, then read back.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         cWe0 = 1'b1;
         cWa0 = 4'(i);
         cWd0 = 32'h1 << i;
      end
      @(negedge clk);
      cWe0 = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         cRa = {4'(i), 4'(15 - i), 4'(i)};
         #2;
         checkOutput($sformatf("c_walk%0d_p0", i), {32'h0, cRd[31:0]}, {32'h0, 32'h1 << i});
         checkOutput($sformatf("c_walk%0d_p1", i), {32'h0, cRd[63:32]}, {32'h0, 32'h1 << (15 - i)});
         checkOutput($sformatf("c_walk%0d_p2", i), {32'h0, cRd[95:64]}, {32'h0, 32'h1 << i});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
